// File: rtl/i2c_pkg.sv
// Shared FSM encoding and I2C engine command codes for the register-access arbiter.
package i2c_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [7:0] CMD_WRREG  = 8'h04;
  localparam logic [7:0] CMD_RDREG  = 8'h05;
  localparam logic [7:0] CMD_STATUS = 8'h06;

  // Engine command selected by a latched direction bit (1 = read).
  function automatic logic [7:0] cmd_code(input logic rw);
    return rw ? CMD_RDREG : CMD_WRREG;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_grant #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = (int'(ptr) + i) % int'(NREQ);
      if (!found && req[PW'(idx)]) begin
        grant[PW'(idx)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C register engine among NREQ requesters,
// with one transaction in flight and a saturating WAIT timeout.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_nack,
  output logic                     rsp_timeout,
  output logic                     eng_wrreg_req,
  output logic                     eng_rdreg_req,
  output logic [ADDR_W-1:0]        eng_addr,
  output logic [DATA_W-1:0]        eng_wrdata,
  input  logic [DATA_W-1:0]        eng_rddata,
  input  logic                     eng_rw_done,
  input  logic                     eng_ack,
  output logic                     busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic                rw_q, rw_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]     grant;
  logic [PW-1:0]       win_idx;
  logic [NREQ-1:0]     req_ready_d, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_d, eng_wrdata_d;
  logic                rsp_nack_d, rsp_timeout_d;
  logic                eng_wrreg_d, eng_rdreg_d, busy_d;
  logic [ADDR_W-1:0]   eng_addr_d;
  logic [ADDR_W-1:0]   addr_arr [NREQ];
  logic [DATA_W-1:0]   data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  rr_grant #(.NREQ(NREQ), .PW(PW)) u_rr_grant (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      rw_q          <= 1'b0;
      cnt_q         <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_nack      <= 1'b0;
      rsp_timeout   <= 1'b0;
      eng_wrreg_req <= 1'b0;
      eng_rdreg_req <= 1'b0;
      eng_addr      <= '0;
      eng_wrdata    <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      rw_q          <= rw_d;
      cnt_q         <= cnt_d;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_nack      <= rsp_nack_d;
      rsp_timeout   <= rsp_timeout_d;
      eng_wrreg_req <= eng_wrreg_d;
      eng_rdreg_req <= eng_rdreg_d;
      eng_addr      <= eng_addr_d;
      eng_wrdata    <= eng_wrdata_d;
      busy          <= busy_d;
    end
  end

  // Next state and next registered outputs; pulses default low, payloads hold.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    rw_d          = rw_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata;
    rsp_nack_d    = rsp_nack;
    rsp_timeout_d = rsp_timeout;
    eng_wrreg_d   = 1'b0;
    eng_rdreg_d   = 1'b0;
    eng_addr_d    = eng_addr;
    eng_wrdata_d  = eng_wrdata;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          owner_d      = win_idx;
          rw_d         = req_rw[win_idx];
          eng_addr_d   = addr_arr[win_idx];
          eng_wrdata_d = data_arr[win_idx];
          req_ready_d  = grant;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_rdreg_d = (cmd_code(rw_q) == CMD_RDREG);
        eng_wrreg_d = (cmd_code(rw_q) == CMD_WRREG);
        cnt_d       = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion wins over a timeout landing on the same edge.
        if (eng_rw_done) begin
          rsp_rdata_d   = eng_rddata;
          rsp_nack_d    = eng_ack;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d   = '0;
          rsp_nack_d    = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        rsp_valid_d[owner_q] = 1'b1;
        rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed + randomized bench for i2c_arbiter against a transaction-level reference model.
module tb_i2c_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 50;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_rw, req_ready, rsp_valid;
  logic [16*NREQ-1:0]   req_addr;
  logic [8*NREQ-1:0]    req_wdata;
  logic [7:0]           rsp_rdata, eng_wrdata, eng_rddata;
  logic                 rsp_nack, rsp_timeout, eng_wrreg_req, eng_rdreg_req;
  logic                 eng_rw_done, eng_ack, busy;
  logic [15:0]          eng_addr;

  i2c_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
    .eng_wrreg_req(eng_wrreg_req), .eng_rdreg_req(eng_rdreg_req),
    .eng_addr(eng_addr), .eng_wrdata(eng_wrdata), .eng_rddata(eng_rddata),
    .eng_rw_done(eng_rw_done), .eng_ack(eng_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int checks = 0;

  // Reference model: requester intents plus the round-robin pointer.
  logic [NREQ-1:0] t_valid;
  logic            t_rw    [NREQ];
  logic [15:0]     t_addr  [NREQ];
  logic [7:0]      t_wdata [NREQ];
  int              ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = t_valid[i];
      req_rw[i]             = t_rw[i];
      req_addr[i*16 +: 16]  = t_addr[i];
      req_wdata[i*8 +: 8]   = t_wdata[i];
    end
  endtask

  function automatic int exp_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (t_valid[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},   32'(req_ready), 32'h0);
    check({tag, ".rsp_valid"},   32'(rsp_valid), 32'h0);
    check({tag, ".rsp_rdata"},   32'(rsp_rdata), 32'h0);
    check({tag, ".rsp_nack"},    32'(rsp_nack), 32'h0);
    check({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'h0);
    check({tag, ".eng_wr"},      32'(eng_wrreg_req), 32'h0);
    check({tag, ".eng_rd"},      32'(eng_rdreg_req), 32'h0);
    check({tag, ".eng_addr"},    32'(eng_addr), 32'h0);
    check({tag, ".eng_wrdata"},  32'(eng_wrdata), 32'h0);
    check({tag, ".busy"},        32'(busy), 32'h0);
  endtask

  // One full transaction; delay = WAIT edges before the done edge (>= TIMEOUT means never done).
  task automatic txn(input int delay, input logic [7:0] edata, input logic eack, output int w);
    logic        rw_e;
    logic [15:0] a_e;
    logic [7:0]  d_e;
    bit          to;
    int          lat;
    w    = exp_winner();
    rw_e = t_rw[w];
    a_e  = t_addr[w];
    d_e  = t_wdata[w];
    to   = (delay >= TIMEOUT);
    tick();
    check("grant.req_ready", 32'(req_ready), 32'(1 << w));
    check("grant.busy", 32'(busy), 32'h1);
    check("grant.rsp_valid", 32'(rsp_valid), 32'h0);
    check("grant.no_eng", 32'({eng_wrreg_req, eng_rdreg_req}), 32'h0);
    // Requests flicker while busy; anything dropped here is simply withdrawn.
    t_valid = NREQ'($urandom);
    drive_reqs();
    tick();
    check("issue.wr", 32'(eng_wrreg_req), 32'(!rw_e));
    check("issue.rd", 32'(eng_rdreg_req), 32'(rw_e));
    check("issue.addr", 32'(eng_addr), 32'(a_e));
    check("issue.wdata", 32'(eng_wrdata), 32'(d_e));
    check("issue.req_ready", 32'(req_ready), 32'h0);
    lat = 0;
    if (!to) begin
      repeat (delay) begin
        eng_rddata = 8'($urandom);
        tick();
        lat++;
        check("wait.no_eng", 32'({eng_wrreg_req, eng_rdreg_req}), 32'h0);
        check("wait.rsp_valid", 32'(rsp_valid), 32'h0);
      end
      eng_rw_done = 1'b1;
      eng_rddata  = edata;
      eng_ack     = eack;
      tick();
      eng_rw_done = 1'b0;
      eng_rddata  = 8'($urandom);
      eng_ack     = 1'($urandom);
      check("done.rsp_valid", 32'(rsp_valid), 32'h0);
      tick();
    end else begin
      while (rsp_valid == '0 && lat < 200) begin
        tick();
        lat++;
        if (rsp_valid == '0)
          check("to.no_eng", 32'({eng_wrreg_req, eng_rdreg_req}), 32'h0);
      end
      check("to.latency_51_52", 32'(lat >= 51 && lat <= 52), 32'h1);
    end
    check("resp.rsp_valid", 32'(rsp_valid), 32'(1 << w));
    check("resp.rdata", 32'(rsp_rdata), to ? 32'h0 : 32'(edata));
    check("resp.nack", 32'(rsp_nack), to ? 32'h0 : 32'(eack));
    check("resp.timeout", 32'(rsp_timeout), 32'(to));
    check("resp.busy", 32'(busy), 32'h0);
    ptr     = (w + 1) % NREQ;
    t_valid = '0;
    drive_reqs();
  endtask

  task automatic set_req(input int i, input logic rw, input logic [15:0] a, input logic [7:0] d);
    t_valid[i] = 1'b1;
    t_rw[i]    = rw;
    t_addr[i]  = a;
    t_wdata[i] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    int order [4] = '{0, 1, 0, 1};
    rst_n = 1'b0;
    eng_rw_done = 1'b0;
    eng_ack = 1'b0;
    eng_rddata = 8'h00;
    t_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      t_rw[i] = 1'b0; t_addr[i] = 16'h0; t_wdata[i] = 8'h0;
    end
    drive_reqs();
    ptr = 0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single write from requester 0.
    set_req(0, 1'b0, 16'h0010, 8'hA5);
    drive_reqs();
    txn(20, 8'h5A, 1'b0, w);
    check("single.winner", 32'(w), 32'h0);

    // Contention right after reset: both requesters stay valid.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ptr = 0;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'($urandom), 16'($urandom), 8'($urandom));
      set_req(1, 1'($urandom), 16'($urandom), 8'($urandom));
      drive_reqs();
      txn(int'($urandom_range(0, 6)), 8'($urandom), 1'($urandom), w);
      check("contend.order", 32'(w), 32'(order[k]));
    end

    // Read with NACK from requester 1.
    set_req(1, 1'b1, 16'h0100, 8'h00);
    drive_reqs();
    txn(7, 8'h3C, 1'b1, w);
    check("read_nack.winner", 32'(w), 32'h1);

    // Randomized traffic with occasional done-on-final-WAIT-cycle.
    for (int n = 0; n < 20; n++) begin
      do t_valid = NREQ'($urandom); while (t_valid == '0);
      for (int i = 0; i < NREQ; i++) begin
        t_rw[i] = 1'($urandom); t_addr[i] = 16'($urandom); t_wdata[i] = 8'($urandom);
      end
      drive_reqs();
      txn((n % 7 == 3) ? TIMEOUT - 1 : int'($urandom_range(0, 12)), 8'($urandom), 1'($urandom), w);
    end

    // Timeout, then a late completion that must be ignored.
    set_req(0, 1'b1, 16'h0BAD, 8'h11);
    drive_reqs();
    txn(TIMEOUT + 10, 8'h00, 1'b0, w);
    eng_rw_done = 1'b1;
    eng_rddata  = 8'hEE;
    eng_ack     = 1'b1;
    tick();
    eng_rw_done = 1'b0;
    tick();
    check("late_done.busy", 32'(busy), 32'h0);
    check("late_done.rsp_valid", 32'(rsp_valid), 32'h0);
    check("late_done.rdata", 32'(rsp_rdata), 32'h0);
    check("late_done.timeout", 32'(rsp_timeout), 32'h1);
    check("late_done.nack", 32'(rsp_nack), 32'h0);
    check("late_done.no_eng", 32'({eng_wrreg_req, eng_rdreg_req}), 32'h0);

    // Done coinciding with the timeout edge.
    set_req(1, 1'b1, 16'h0200, 8'h00);
    drive_reqs();
    txn(TIMEOUT - 1, 8'h9D, 1'b0, w);

    // Reset in the middle of WAIT.
    set_req(1, 1'b0, 16'h0300, 8'h42);
    drive_reqs();
    tick();
    check("midrst.grant", 32'(req_ready), 32'(1 << exp_winner()));
    t_valid = '0;
    drive_reqs();
    tick();
    check("midrst.pulse", 32'(eng_wrreg_req), 32'h1);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    ptr = 0;
    repeat (3) begin
      tick();
      check("midrst.no_rsp", 32'(rsp_valid), 32'h0);
      check("midrst.idle", 32'(busy), 32'h0);
    end
    set_req(0, 1'b1, 16'h0400, 8'h00);
    set_req(1, 1'b1, 16'h0500, 8'h00);
    drive_reqs();
    txn(3, 8'h77, 1'b0, w);
    check("midrst.first_grant", 32'(w), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1000000, giving the maximum number of WAIT cycles before a transaction is abandoned.
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock; one clock, all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  NREQ  per-requester transaction request; held until accepted.
- req_rw  in  NREQ  per-requester direction; 1 = read, 0 = write.
- req_addr  in  16*NREQ  per-requester register address; requester i uses bits [16i+15:16i].
- req_wdata  in  8*NREQ  per-requester write byte.
- req_ready  out  NREQ  one-cycle accept pulse to the granted requester.
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  8  read byte; valid with rsp_valid.
- rsp_nack  out  1  engine reported NACK; valid with rsp_valid.
- rsp_timeout  out  1  transaction timed out; valid with rsp_valid.
- eng_wrreg_req  out  1  one-cycle write pulse to the single-byte I2C engine.
- eng_rdreg_req  out  1  one-cycle read pulse to the single-byte I2C engine.
- eng_addr  out  16  engine register address; held stable from ISSUE through RESP.
- eng_wrdata  out  8  engine write byte; held stable from ISSUE through RESP.
- eng_rddata  in  8  engine read byte.
- eng_rw_done  in  1  engine completion pulse.
- eng_ack  in  1  engine acknowledge status; 1 = NACK.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with exactly one engine transaction in flight at any time.
REQ-005 In IDLE with any req_valid bit set, the block SHALL select a winner round-robin starting from rr_ptr, ascending and wrapping from NREQ-1 to 0.
- On the selecting edge it SHALL latch the winner's rw, addr and wdata.
- It SHALL pulse req_ready[winner] for one cycle and enter ISSUE.
REQ-006 ISSUE SHALL assert exactly one of eng_rdreg_req or eng_wrreg_req (chosen by the latched rw) for exactly one cycle, clear the timeout counter, and enter WAIT.
REQ-007 In WAIT, on eng_rw_done the block SHALL latch eng_rddata into rsp_rdata and eng_ack into rsp_nack, clear rsp_timeout, and enter RESP.
REQ-008 In WAIT, when the counter reaches TIMEOUT_CYC-1 without eng_rw_done, the block SHALL set rsp_timeout=1, rsp_nack=0 and rsp_rdata=8'h00, and enter RESP.
REQ-009 If eng_rw_done and the timeout coincide, eng_rw_done SHALL take priority and rsp_timeout SHALL be 0.
REQ-010 RESP SHALL pulse rsp_valid[owner] for one cycle, set rr_ptr to (owner+1) mod NREQ, and return to IDLE.
- rsp_rdata, rsp_nack and rsp_timeout SHALL hold their values until the next RESP.
REQ-011 eng_rw_done outside WAIT SHALL be ignored, with no state or output change.
REQ-012 Minimum latency SHALL be fixed:
- req_valid sampled in IDLE at edge N gives req_ready at N, an engine pulse at N+1, and rsp_valid one cycle after the WAIT edge that sees eng_rw_done.
- Back-to-back transactions SHALL have no idle gap beyond the single IDLE cycle.
REQ-013 req_valid dropped by a requester before its req_ready SHALL withdraw that request without error.
REQ-014 The timeout counter SHALL be $clog2(TIMEOUT_CYC) bits wide and saturate; it SHALL NOT wrap.

Reset
REQ-015 While rst_n=0 at a clock edge, the block SHALL force the following, aborting any in-flight transaction with no rsp_valid issued:
- state=IDLE, rr_ptr=0;
- req_ready=0, rsp_valid=0, rsp_rdata=8'h00, rsp_nack=0, rsp_timeout=0;
- eng_wrreg_req=0, eng_rdreg_req=0, eng_addr=16'h0000, eng_wrdata=8'h00;
- busy=0.
REQ-016 The first grant after reset SHALL go to the lowest-indexed valid requester.

Structure
REQ-017 The FSM state encoding and the I2C command codes 8'h04, 8'h05 and 8'h06 SHALL live in shared package i2c_pkg.
REQ-018 Round-robin selection SHALL be one combinational sub-module, rr_grant (inputs: request vector, pointer; output: one-hot grant).
- All other logic SHALL be in i2c_arbiter.

Verification
REQ-019 Single write: req0 write addr 16'h0010 data 8'hA5, engine done after 20 cycles, ack=0.
- Expect one eng_wrreg_req, eng_addr=16'h0010 and eng_wrdata=8'hA5.
- Expect rsp_valid[0] with rsp_nack=0.
REQ-020 Contention: req0 and req1 valid on the same cycle after reset.
- Expect the grant order 0,1,0,1 over four transactions.
- Expect no engine pulse while busy from the previous transaction.
REQ-021 Read NACK: req1 read addr 16'h0100, engine returns rddata 8'h3C with ack=1.
- Expect rsp_valid[1], rsp_rdata=8'h3C and rsp_nack=1.
REQ-022 Timeout: TIMEOUT_CYC=50 and eng_rw_done never asserted.
- Expect rsp_valid 51-52 cycles after the engine pulse, rsp_timeout=1 and rsp_rdata=8'h00.
- Expect a late eng_rw_done to be ignored.
REQ-023 Simultaneous done and timeout: eng_rw_done on the final WAIT cycle.
- Expect rsp_timeout=0 and rsp_rdata equal to the engine data.
REQ-024 Reset mid-WAIT: assert rst_n=0 for one cycle during WAIT.
- Expect all outputs at reset values, no rsp_valid, and the next grant to the lowest-indexed valid requester.
